// File: rtl/clock_divider_ctrl_if.sv
// Divisor update channel for clock_divider_ctrl: valid/ready transfer plus an
// error pulse returned when an accepted divisor is illegal and dropped.
interface clock_divider_ctrl_if #(
  parameter int unsigned DIV_WIDTH = 8
);
  logic                 div_valid;
  logic [DIV_WIDTH-1:0] div_value;
  logic                 div_ready;
  logic                 div_err;

  modport master (
    output div_valid,
    output div_value,
    input  div_ready,
    input  div_err
  );

  modport slave (
    input  div_valid,
    input  div_value,
    output div_ready,
    output div_err
  );
endinterface

// File: rtl/clock_divider_ctrl.sv
// Run-time integer clock divider controller: glitch-free divisor updates on period
// boundaries, clean start/stop. Optional period counter: CLKDIV_CTRL_PERIOD_CNT_EN.
module clock_divider_ctrl #(
  parameter int unsigned DIV_WIDTH   = 8,
  parameter int unsigned DEFAULT_DIV = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  clock_divider_ctrl_if.slave      div_if,
  output logic                     out,
  output logic                     tick,
  output logic                     running,
  output logic [DIV_WIDTH-1:0]     cur_div
`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
  ,
  output logic [15:0]              period_count
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StStopping} state_e;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] cur_div_q, cur_div_d;
  logic [DIV_WIDTH-1:0] pend_q, pend_d;
  logic                 pend_valid_q, pend_valid_d;
  logic                 out_q, out_d;
  logic                 tick_q, tick_d;
  logic                 running_q, running_d;
  logic                 div_err_q, div_err_d;

  logic                 last;
  logic                 wrap;
  logic                 xfer;

  // cur_div is always >= 2, so cur_div-1 never underflows and the compare is full width.
  assign last = (cnt_q == (cur_div_q - DIV_WIDTH'(1)));
  assign wrap = (state_q != StIdle) && last;
  assign xfer = div_if.div_valid && !pend_valid_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_div_d    = cur_div_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    div_err_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (en) begin
          state_d = StRun;
        end
      end
      StRun: begin
        cnt_d = last ? '0 : cnt_q + DIV_WIDTH'(1);
        if (!en) begin
          state_d = last ? StIdle : StStopping;
        end
      end
      StStopping: begin
        cnt_d = last ? '0 : cnt_q + DIV_WIDTH'(1);
        if (en) begin
          state_d = StRun;
        end else if (last) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // A held divisor takes effect at the period boundary, or at once if already idle.
    if (pend_valid_q && (wrap || (state_q == StIdle))) begin
      cur_div_d    = pend_q;
      pend_valid_d = 1'b0;
    end

    // xfer implies no pending value, so this never races the apply above.
    if (xfer) begin
      if (div_if.div_value < DIV_WIDTH'(2)) begin
        div_err_d = 1'b1;
      end else if (state_q == StIdle) begin
        cur_div_d = div_if.div_value;
      end else begin
        pend_d       = div_if.div_value;
        pend_valid_d = 1'b1;
      end
    end

    running_d = (state_d != StIdle);
    tick_d    = running_d && (cnt_d == '0);
    out_d     = running_d && (cnt_d < (cur_div_d >> 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      cur_div_q    <= DIV_WIDTH'(DEFAULT_DIV);
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      out_q        <= 1'b0;
      tick_q       <= 1'b0;
      running_q    <= 1'b0;
      div_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_div_q    <= cur_div_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      out_q        <= out_d;
      tick_q       <= tick_d;
      running_q    <= running_d;
      div_err_q    <= div_err_d;
    end
  end

  assign out              = out_q;
  assign tick             = tick_q;
  assign running          = running_q;
  assign cur_div          = cur_div_q;
  assign div_if.div_ready = !pend_valid_q;
  assign div_if.div_err   = div_err_q;

`ifdef CLKDIV_CTRL_PERIOD_CNT_EN
  logic [15:0] period_count_q, period_count_d;

  always_comb begin
    period_count_d = period_count_q;
    if (tick_d && (period_count_q != 16'hFFFF)) begin
      period_count_d = period_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_count_q <= '0;
    end else begin
      period_count_q <= period_count_d;
    end
  end

  assign period_count = period_count_q;
`endif

  a_tick_running : assert property (@(posedge clk) disable iff (!rst) tick_q |-> running_q);
  a_out_running  : assert property (@(posedge clk) disable iff (!rst) out_q |-> running_q);
  a_div_legal    : assert property (@(posedge clk) disable iff (!rst) cur_div_q >= DIV_WIDTH'(2));
  a_cnt_in_range : assert property (@(posedge clk) disable iff (!rst) cnt_q < cur_div_q);

endmodule
